// File: rtl/sync_payload_rx_pkg.sv
// Shared types and constants for the sync_payload_rx receiver.
//   rx_state_t   : receiver FSM state encoding (2'b11 is unused and decodes to IDLE)
//   SYNC_PATTERN : serial pattern recognised by the upstream detector
package sync_payload_rx_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RECEIVE = 2'b01,
    LOAD    = 2'b10
  } rx_state_t;

  localparam logic [3:0] SYNC_PATTERN = 4'b1101;

endpackage

// File: rtl/sync_payload_rx_if.sv
// Bus bundle between a serial source / word consumer and sync_payload_rx.
//   serial_in     : serial bit stream, one bit per clock
//   sync_detect   : sync pulse from the upstream 1101 detector
//   data_read     : consumer acknowledge
//   rx_data       : captured payload word
//   data_ready    : unread word available
//   overrun_error : sticky, an unread word was overwritten
//   rx_busy       : a frame is being received or loaded
// master = source/consumer side, slave = receiver side.
interface sync_payload_rx_if #(
  parameter int PAYLOAD_BITS = 8
);

  logic                    serial_in;
  logic                    sync_detect;
  logic                    data_read;
  logic [PAYLOAD_BITS-1:0] rx_data;
  logic                    data_ready;
  logic                    overrun_error;
  logic                    rx_busy;

  modport master (
    output serial_in, sync_detect, data_read,
    input  rx_data, data_ready, overrun_error, rx_busy
  );

  modport slave (
    input  serial_in, sync_detect, data_read,
    output rx_data, data_ready, overrun_error, rx_busy
  );

endinterface

// File: rtl/sync_payload_rx_bit_counter.sv
// Up counter used as the payload bit index.
//   clk, n_rst    : clock, asynchronous active-low reset
//   clear         : synchronous clear to zero (wins over count_enable)
//   count_enable  : increment by one
//   rollover_val  : terminal count
//   rollover_flag : registered, high while the count equals rollover_val
module payload_bit_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             count_enable,
  input  logic [WIDTH-1:0] rollover_val,
  output logic             rollover_flag
);

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_next;
  logic             flag_next;

  // The flag is computed from the next count so that it is valid in the
  // same cycle the count reaches rollover_val, without a compare delay.
  always_comb begin
    count_next = count;
    flag_next  = rollover_flag;
    if (clear) begin
      count_next = '0;
      flag_next  = (rollover_val == '0);
    end else if (count_enable) begin
      count_next = count + 1'b1;
      flag_next  = (count_next == rollover_val);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count         <= '0;
      rollover_flag <= 1'b0;
    end else begin
      count         <= count_next;
      rollover_flag <= flag_next;
    end
  end

endmodule

// File: rtl/sync_payload_rx.sv
// Serial payload receiver: after each sync pulse from the 1101 detector it
// captures the next PAYLOAD_BITS serial bits into a parallel word, presents
// it with a ready/read handshake and flags overrun of an unread word.
//   clk   : system clock, one serial bit per rising edge
//   n_rst : asynchronous active-low reset
//   bus   : sync_payload_rx_if slave (serial_in, sync_detect, data_read in;
//           rx_data, data_ready, overrun_error, rx_busy out, all registered)
// Parameters: PAYLOAD_BITS (2..32), MSB_FIRST (1: first bit lands in MSB).
module sync_payload_rx
  import sync_payload_rx_pkg::*;
#(
  parameter int PAYLOAD_BITS = 8,
  parameter bit MSB_FIRST    = 1'b1
) (
  input  logic                 clk,
  input  logic                 n_rst,
  sync_payload_rx_if.slave     bus
);

  localparam int                CNT_W    = $clog2(PAYLOAD_BITS + 1);
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(PAYLOAD_BITS - 1);

  rx_state_t               state;
  rx_state_t               state_next;
  logic [PAYLOAD_BITS-1:0] shreg;
  logic [PAYLOAD_BITS-1:0] shift_in;
  logic                    cnt_clear;
  logic                    cnt_en;
  logic                    last_bit;

  logic [PAYLOAD_BITS-1:0] rx_data;
  logic                    data_ready;
  logic                    overrun_error;
  logic                    rx_busy;

  payload_bit_counter #(
    .WIDTH (CNT_W)
  ) u_bit_counter (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (cnt_clear),
    .count_enable  (cnt_en),
    .rollover_val  (LAST_IDX),
    .rollover_flag (last_bit)
  );

  if (MSB_FIRST) begin : g_msb_first
    assign shift_in = {shreg[PAYLOAD_BITS-2:0], bus.serial_in};
  end else begin : g_lsb_first
    assign shift_in = {bus.serial_in, shreg[PAYLOAD_BITS-1:1]};
  end

  // The sync-cycle bit belongs to the pattern, so capture starts on the
  // following edge. sync_detect is only looked at in IDLE, which lets a
  // payload legally contain 1101. The unused 2'b11 encoding falls into
  // the default branch and behaves as IDLE.
  always_comb begin
    state_next = state;
    cnt_clear  = 1'b0;
    cnt_en     = 1'b0;
    case (state)
      RECEIVE: begin
        cnt_en = 1'b1;
        if (last_bit) state_next = LOAD;
      end
      LOAD: state_next = IDLE;
      default: begin
        if (bus.sync_detect) begin
          state_next = RECEIVE;
          cnt_clear  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      shreg   <= '0;
      rx_busy <= 1'b0;
    end else begin
      state   <= state_next;
      rx_busy <= (state_next == RECEIVE) || (state_next == LOAD);
      if (state == RECEIVE) shreg <= shift_in;
    end
  end

  // A load takes priority over a simultaneous read: the new word stays
  // unread, and a read in that cycle still acknowledges any old overrun.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_data       <= '0;
      data_ready    <= 1'b0;
      overrun_error <= 1'b0;
    end else if (state == LOAD) begin
      rx_data    <= shreg;
      data_ready <= 1'b1;
      if (bus.data_read)   overrun_error <= 1'b0;
      else if (data_ready) overrun_error <= 1'b1;
    end else if (bus.data_read) begin
      data_ready    <= 1'b0;
      overrun_error <= 1'b0;
    end
  end

  assign bus.rx_data       = rx_data;
  assign bus.data_ready    = data_ready;
  assign bus.overrun_error = overrun_error;
  assign bus.rx_busy       = rx_busy;

endmodule

// File: tb/tb_sync_payload_rx.sv
// Testbench for sync_payload_rx: an MSB-first and an LSB-first instance
// share one stimulus stream; a behavioural 1101 detector produces
// sync_detect. Each frame pushes its expected word into a queue per
// instance and a monitor pops and compares whenever an instance finishes
// a load (rx_busy falls).
module tb_sync_payload_rx;
  import sync_payload_rx_pkg::*;

  typedef struct packed {
    logic [7:0] data;
    logic       ready;
    logic       ovr;
  } exp_t;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic serial = 1'b0;
  logic sync_force = 1'b0;
  logic data_read = 1'b0;
  logic [2:0] hist = 3'b000;
  logic sync;

  int n_checks = 0;
  int n_pass = 0;
  exp_t q_msb[$];
  exp_t q_lsb[$];
  logic m_ready = 1'b0;
  logic m_ovr = 1'b0;
  logic prev_busy_msb = 1'b0;
  logic prev_busy_lsb = 1'b0;

  sync_payload_rx_if #(.PAYLOAD_BITS(8)) bus_msb ();
  sync_payload_rx_if #(.PAYLOAD_BITS(8)) bus_lsb ();

  sync_payload_rx #(.PAYLOAD_BITS(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus_msb)
  );

  sync_payload_rx #(.PAYLOAD_BITS(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus_lsb)
  );

  always #5 clk = ~clk;

  // Mealy 1101 detector on the same stream, plus an override for forcing
  always @(posedge clk) hist <= {hist[1:0], serial};
  assign sync = ({hist, serial} == SYNC_PATTERN) | sync_force;

  assign bus_msb.serial_in   = serial;
  assign bus_msb.sync_detect = sync;
  assign bus_msb.data_read   = data_read;
  assign bus_lsb.serial_in   = serial;
  assign bus_lsb.sync_detect = sync;
  assign bus_lsb.data_read   = data_read;

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_msb_rx_data"}, 32'(bus_msb.rx_data), 32'h0);
    chk({tag, "_msb_ready"},   32'(bus_msb.data_ready), 32'h0);
    chk({tag, "_msb_ovr"},     32'(bus_msb.overrun_error), 32'h0);
    chk({tag, "_msb_busy"},    32'(bus_msb.rx_busy), 32'h0);
    chk({tag, "_lsb_rx_data"}, 32'(bus_lsb.rx_data), 32'h0);
    chk({tag, "_lsb_busy"},    32'(bus_lsb.rx_busy), 32'h0);
  endtask

  task automatic send_bit(input logic b, input logic f);
    serial = b;
    sync_force = f;
    @(posedge clk);
    #1;
  endtask

  task automatic send_sync();
    repeat (4) send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);   // sync-accept edge E0
    chk("busy_after_sync", 32'(bus_msb.rx_busy), 32'h1);
  endtask

  task automatic send_frame(input logic [7:0] p, input bit read_on_load, input int force_idx);
    if (read_on_load) m_ovr = 1'b0;
    else if (m_ready) m_ovr = 1'b1;
    m_ready = 1'b1;
    q_msb.push_back('{data: p, ready: 1'b1, ovr: m_ovr});
    q_lsb.push_back('{data: rev8(p), ready: 1'b1, ovr: m_ovr});
    send_sync();
    for (int i = 0; i < 8; i++) send_bit(p[7-i], (i == force_idx));
    chk("busy_in_load", 32'(bus_msb.rx_busy), 32'h1);
    data_read = read_on_load;
    send_bit(1'b0, 1'b0);   // LOAD edge E9
    data_read = 1'b0;
  endtask

  task automatic read_pulse();
    data_read = 1'b1;
    @(posedge clk);
    #1;
    data_read = 1'b0;
    m_ready = 1'b0;
    m_ovr = 1'b0;
    chk("read_msb_ready", 32'(bus_msb.data_ready), 32'h0);
    chk("read_msb_ovr",   32'(bus_msb.overrun_error), 32'h0);
    chk("read_lsb_ready", 32'(bus_lsb.data_ready), 32'h0);
    chk("read_lsb_ovr",   32'(bus_lsb.overrun_error), 32'h0);
  endtask

  // Monitor: a completed load shows as rx_busy falling outside reset
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        prev_busy_msb = 1'b0;
        prev_busy_lsb = 1'b0;
      end else begin
        if (prev_busy_msb && !bus_msb.rx_busy) begin
          if (q_msb.size() == 0) begin
            n_checks++;
            $display("FAIL msb_unexpected_load: got rx_data %0h expected no load", bus_msb.rx_data);
          end else begin
            e = q_msb.pop_front();
            chk("msb_rx_data", 32'(bus_msb.rx_data), 32'(e.data));
            chk("msb_ready",   32'(bus_msb.data_ready), 32'(e.ready));
            chk("msb_ovr",     32'(bus_msb.overrun_error), 32'(e.ovr));
          end
        end
        if (prev_busy_lsb && !bus_lsb.rx_busy) begin
          if (q_lsb.size() == 0) begin
            n_checks++;
            $display("FAIL lsb_unexpected_load: got rx_data %0h expected no load", bus_lsb.rx_data);
          end else begin
            e = q_lsb.pop_front();
            chk("lsb_rx_data", 32'(bus_lsb.rx_data), 32'(e.data));
            chk("lsb_ready",   32'(bus_lsb.data_ready), 32'(e.ready));
            chk("lsb_ovr",     32'(bus_lsb.overrun_error), 32'(e.ovr));
          end
        end
        prev_busy_msb = bus_msb.rx_busy;
        prev_busy_lsb = bus_lsb.rx_busy;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held with random inputs
    n_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      serial = 1'($urandom_range(0, 1));
      sync_force = 1'($urandom_range(0, 1));
      data_read = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      chk_cleared("in_reset");
    end
    serial = 1'b0;
    sync_force = 1'b0;
    data_read = 1'b0;
    n_rst = 1'b1;
    repeat (5) send_bit(1'b0, 1'b0);
    chk_cleared("after_release");

    // Basic frame A7 (LSB-first instance sees E5), then acknowledge
    send_frame(8'hA7, 1'b0, -1);
    read_pulse();

    // Sync forced high at payload bit 3 must be ignored
    send_frame(8'hA7, 1'b0, 3);
    read_pulse();

    // Two frames without a read: overrun
    send_frame(8'h3C, 1'b0, -1);
    send_frame(8'hC3, 1'b0, -1);
    read_pulse();

    // Read coincident with the second LOAD edge: load wins, no overrun
    send_frame(8'h3C, 1'b0, -1);
    send_frame(8'hC3, 1'b1, -1);
    read_pulse();

    // Reset after 4 payload bits, then a clean frame
    send_sync();
    for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
    #2;
    n_rst = 1'b0;
    #1;
    chk_cleared("async_reset");
    m_ready = 1'b0;
    m_ovr = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    serial = 1'b0;
    n_rst = 1'b1;
    chk_cleared("after_abort");
    send_frame(8'h5A, 1'b0, -1);
    read_pulse();

    repeat (3) send_bit(1'b0, 1'b0);
    while (q_msb.size() != 0) begin
      void'(q_msb.pop_front());
      n_checks++;
      $display("FAIL msb_missing_load: got no load expected a word");
    end
    while (q_lsb.size() != 0) begin
      void'(q_lsb.pop_front());
      n_checks++;
      $display("FAIL lsb_missing_load: got no load expected a word");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
